// File: rtl/pll_reset_seq_pkg.sv
// Shared types and default timing constants for the PLL reset sequencer.
package pll_reset_seq_pkg;

    typedef enum logic [2:0] {
        PRST   = 3'd0,
        WAIT   = 3'd1,
        STABLE = 3'd2,
        POST   = 3'd3,
        RUN    = 3'd4
    } state_t;

    localparam int RST_CYC_DEF     = 16;
    localparam int STABLE_CYC_DEF  = 1024;
    localparam int TIMEOUT_CYC_DEF = 65535;
    localparam int POST_CYC_DEF    = 64;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous bit.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_seq.sv
// Sequences PLL reset, waits for a stable lock, then releases the system reset.
module pll_reset_seq
    import pll_reset_seq_pkg::*;
#(
    parameter int RST_CYC     = RST_CYC_DEF,
    parameter int STABLE_CYC  = STABLE_CYC_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int POST_CYC    = POST_CYC_DEF
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       sys_reset,
    output logic       ready,
    output logic [7:0] loss_cnt,
    output logic [7:0] retry_cnt
);

    localparam logic [15:0] RST_T  = 16'(RST_CYC - 1);
    localparam logic [15:0] STB_T  = 16'(STABLE_CYC - 1);
    localparam logic [15:0] TO_T   = 16'(TIMEOUT_CYC - 1);
    localparam logic [15:0] POST_T = 16'(POST_CYC - 1);

    state_t      state, state_nx;
    logic [15:0] cnt;
    logic        lk;
    logic        entry;
    logic        loss_inc;
    logic        retry_inc;

    sync2 u_lk_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lk)
    );

    // relock_req overrides every other transition and never counts as an event
    always_comb begin
        state_nx  = state;
        loss_inc  = 1'b0;
        retry_inc = 1'b0;
        if (relock_req) begin
            state_nx = PRST;
        end else begin
            case (state)
                PRST:   if (cnt == RST_T) state_nx = WAIT;
                WAIT:   if (lk) state_nx = STABLE;
                        else if (cnt == TO_T) begin
                            state_nx  = PRST;
                            retry_inc = 1'b1;
                        end
                STABLE: if (!lk) state_nx = WAIT;
                        else if (cnt == STB_T) state_nx = POST;
                POST:   if (!lk) state_nx = PRST;
                        else if (cnt == POST_T) state_nx = RUN;
                RUN:    if (!lk) begin
                            state_nx = PRST;
                            loss_inc = 1'b1;
                        end
                default: state_nx = PRST;
            endcase
        end
        entry = relock_req || (state_nx != state);
    end

    // Outputs are registered from the next state so they line up with the state register
    always_ff @(posedge refclk) begin
        if (rst) begin
            state     <= PRST;
            cnt       <= 16'd0;
            loss_cnt  <= 8'd0;
            retry_cnt <= 8'd0;
            pll_rst   <= 1'b1;
            sys_reset <= 1'b1;
            ready     <= 1'b0;
        end else begin
            state     <= state_nx;
            if (entry)               cnt <= 16'd0;
            else if (cnt != 16'hFFFF) cnt <= cnt + 16'd1;
            if (loss_inc)  loss_cnt  <= sat_inc(loss_cnt);
            if (retry_inc) retry_cnt <= sat_inc(retry_cnt);
            pll_rst   <= (state_nx == PRST);
            sys_reset <= (state_nx != RUN);
            ready     <= (state_nx == RUN);
        end
    end

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed bench for pll_reset_seq with short timing parameters.
module tb_pll_reset_seq;

    logic       refclk = 1'b0;
    logic       rst, pll_locked, relock_req;
    logic       pll_rst, sys_reset, ready;
    logic [7:0] loss_cnt, retry_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    int n;

    pll_reset_seq #(
        .RST_CYC     (16),
        .STABLE_CYC  (8),
        .TIMEOUT_CYC (100),
        .POST_CYC    (4)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .relock_req (relock_req),
        .pll_rst    (pll_rst),
        .sys_reset  (sys_reset),
        .ready      (ready),
        .loss_cnt   (loss_cnt),
        .retry_cnt  (retry_cnt)
    );

    always #10 refclk = ~refclk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        pll_locked = 1'b0;
        relock_req = 1'b0;
        repeat (3) tick();
        chk("rst_pll_rst",   int'(pll_rst),   1);
        chk("rst_sys_reset", int'(sys_reset), 1);
        chk("rst_ready",     int'(ready),     0);
        chk("rst_loss",      int'(loss_cnt),  0);
        chk("rst_retry",     int'(retry_cnt), 0);

        // power-up: PRST lasts 16 cycles after release
        rst = 1'b0;
        n = 0;
        do begin tick(); n++; end while (pll_rst && n < 200);
        chk("pwr_prst_len", n, 16);

        // lock 10 cycles after pll_rst falls; ready 2+8+4 edges after the first edge sampling it
        repeat (9) tick();
        pll_locked = 1'b1;
        tick();
        n = 0;
        do begin tick(); n++; end while (!ready && n < 200);
        chk("pwr_ready_lat", n, 14);
        chk("pwr_sys_reset", int'(sys_reset), 0);
        chk("pwr_loss",      int'(loss_cnt),  0);
        chk("pwr_retry",     int'(retry_cnt), 0);

        // relock from RUN, then 1-cycle glitch in the 5th STABLE cycle
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        chk("relock_pll_rst", int'(pll_rst),   1);
        chk("relock_sysrst",  int'(sys_reset), 1);
        chk("relock_ready",   int'(ready),     0);
        chk("relock_loss",    int'(loss_cnt),  0);
        n = 0;
        do begin tick(); n++; end while (pll_rst && n < 200);
        chk("relock_prst_len", n, 16);
        repeat (3) tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!ready && n < 200);
        chk("glitch_ready_lat", n, 15);
        chk("glitch_loss",      int'(loss_cnt), 0);

        // relock coinciding with synchronized lock loss in RUN
        pll_locked = 1'b0;
        tick();
        tick();
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        chk("coin_pll_rst", int'(pll_rst),   1);
        chk("coin_sysrst",  int'(sys_reset), 1);
        chk("coin_loss",    int'(loss_cnt),  0);

        // lock never arrives: 16 PRST + 100 WAIT per attempt
        n = 0;
        do begin tick(); n++; end while (pll_rst && n < 300);
        chk("to_prst_len", n, 16);
        n = 0;
        do begin tick(); n++; end while (!pll_rst && n < 300);
        chk("to_wait_len", n, 100);
        chk("to_retry1", int'(retry_cnt), 1);
        for (int k = 2; k <= 3; k++) begin
            n = 0;
            do begin tick(); n++; end while (pll_rst && n < 300);
            do begin tick(); n++; end while (!pll_rst && n < 300);
            chk("to_period", n, 116);
            chk("to_retry",  int'(retry_cnt), k);
        end

        // 300 lock drops in RUN: loss_cnt saturates at 255
        pll_locked = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!ready && n < 200);
        chk("loss_pre_ready", int'(ready), 1);
        for (int i = 0; i < 300; i++) begin
            pll_locked = 1'b0;
            n = 0;
            do begin tick(); n++; end while (!sys_reset && n < 10);
            chk("loss_sysrst_lat", n, 3);
            if (i == 0 || i == 253 || i == 254 || i == 255 || i == 299)
                chk("loss_cnt", int'(loss_cnt), (i + 1 > 255) ? 255 : i + 1);
            pll_locked = 1'b1;
            n = 0;
            do begin tick(); n++; end while (!ready && n < 100);
        end
        chk("loss_post_ready", int'(ready),     1);
        chk("loss_retry",      int'(retry_cnt), 3);

        // rst while in POST
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        n = 0;
        do begin tick(); n++; end while (pll_rst && n < 200);
        repeat (10) tick();
        chk("post_sysrst", int'(sys_reset), 1);
        chk("post_ready",  int'(ready),     0);
        rst = 1'b1;
        tick();
        chk("prst_pll_rst", int'(pll_rst),   1);
        chk("prst_sysrst",  int'(sys_reset), 1);
        chk("prst_ready",   int'(ready),     0);
        chk("prst_loss",    int'(loss_cnt),  0);
        chk("prst_retry",   int'(retry_cnt), 0);
        rst = 1'b0;
        n = 0;
        do begin tick(); n++; end while (pll_rst && n < 200);
        chk("prst_len", n, 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
